wb_reg_file: RTL and testbench

// - Write-back stage plus architectural register file; consumes the MEM/WB pipeline register outputs.
// - Selects the write-back value (load data or ALU result) and commits it to the register file on the clock edge.
// - Serves the two ID-stage source-operand read ports.
// - Write-through bypass: ID sees a value in the same cycle WB writes it, so no WB->ID hazard stall is needed.

---
 rtl/wb_reg_file.sv | 107 ++++++++++
 tb/tb_wb_reg_file.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_reg_file.sv
// wb_reg_file
//   Write-back stage plus architectural register file. Picks the write-back
//   value (load data or ALU result). Commits that value to the register file
//   on the rising clock edge. Serves the two ID-stage source-operand read
//   ports. Reads are write-first: when WB writes a register in a cycle, ID
//   sees the new value in that same cycle, so no WB->ID stall is needed.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset; clears every register
//   WB_EN       write-back enable from MEM/WB
//   MEM_R_EN    1: write memReadVal, 0: write ALURes
//   ALURes      ALU result from MEM/WB
//   memReadVal  load data from MEM/WB
//   dest        destination register index
//   src1, src2  ID read-port indices
//   reg1, reg2  ID read-port data (combinational)
//   WB_Value    selected write-back value, for the forwarding unit
`timescale 1ns/1ps
module wb_reg_file #(
  parameter int WORD_LEN          = 32,
  parameter int REG_FILE_ADDR_LEN = 5,
  parameter int REG_COUNT         = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         WB_EN,
  input  logic                         MEM_R_EN,
  input  logic [WORD_LEN-1:0]          ALURes,
  input  logic [WORD_LEN-1:0]          memReadVal,
  input  logic [REG_FILE_ADDR_LEN-1:0] dest,
  input  logic [REG_FILE_ADDR_LEN-1:0] src1,
  input  logic [REG_FILE_ADDR_LEN-1:0] src2,
  output logic [WORD_LEN-1:0]          reg1,
  output logic [WORD_LEN-1:0]          reg2,
  output logic [WORD_LEN-1:0]          WB_Value
);

  logic [WORD_LEN-1:0] regs_q [REG_COUNT];
  logic [WORD_LEN-1:0] regs_d [REG_COUNT];
  logic                write_ok;

  // Indices at or above REG_COUNT name no register. This is only possible
  // when REG_COUNT < 2**REG_FILE_ADDR_LEN.
  function automatic logic in_range(input logic [REG_FILE_ADDR_LEN-1:0] idx);
    return int'(idx) < REG_COUNT;
  endfunction

  // The MEM_R_EN mux is purely combinational. It does not depend on WB_EN,
  // and it keeps running during reset.
  assign WB_Value = MEM_R_EN ? memReadVal : ALURes;

  assign write_ok = WB_EN && (dest != '0) && in_range(dest);

  always_comb begin
    // NOTE: start from the current state so every element of regs_d is
    // assigned on every path; otherwise the tool infers latches.
    regs_d = regs_q;
    if (write_ok) begin
      regs_d[dest] = WB_Value;
    end
    regs_d[0] = '0;
  end

  // An edge that arrives while rst is high takes the reset branch. Such an
  // edge therefore commits nothing. The first write lands on the first edge
  // after rst falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the whole array is cleared in the async reset on purpose, since
      // the architectural state must read zero straight out of reset. That
      // makes these flops rather than a RAM macro.
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking for state, so every reader of regs_q in this
      // cycle sees the pre-edge value.
      regs_q <= regs_d;
    end
  end

  // Read priority: rst, then index 0, then out of range, then the
  // same-cycle bypass from WB, then the stored value.
  always_comb begin
    reg1 = '0;
    if (!rst && (src1 != '0) && in_range(src1)) begin
      if (WB_EN && (dest == src1)) begin
        reg1 = WB_Value;
      end else begin
        reg1 = regs_q[src1];
      end
    end
  end

  always_comb begin
    reg2 = '0;
    if (!rst && (src2 != '0) && in_range(src2)) begin
      if (WB_EN && (dest == src2)) begin
        reg2 = WB_Value;
      end else begin
        reg2 = regs_q[src2];
      end
    end
  end

endmodule

// File: tb/tb_wb_reg_file.sv
// tb_wb_reg_file
//   Self-checking bench for wb_reg_file. The reference model is an array
//   holding the architectural register contents. A read is expected to return
//   the state as it will stand once this cycle's write has landed, which is
//   the write-first view. Reset empties the model at once.
`timescale 1ns/1ps
module tb_wb_reg_file;

  logic        clk;
  logic        rst;
  logic        we;
  logic        mr;
  logic [31:0] alu;
  logic [31:0] mem;
  logic [4:0]  dest;
  logic [4:0]  src1;
  logic [4:0]  src2;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [31:0] wb_value;

  logic [31:0] model [32];
  int          n_checks = 0;
  int          n_pass   = 0;

  wb_reg_file #(
    .WORD_LEN         (32),
    .REG_FILE_ADDR_LEN(5),
    .REG_COUNT        (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .WB_EN     (we),
    .MEM_R_EN  (mr),
    .ALURes    (alu),
    .memReadVal(mem),
    .dest      (dest),
    .src1      (src1),
    .src2      (src2),
    .reg1      (reg1),
    .reg2      (reg2),
    .WB_Value  (wb_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        mr;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0]  dest;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ewb;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [31:0] exp_wb();
    return mr ? mem : alu;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] s);
    logic [31:0] committed [32];
    committed = model;
    if (we && dest != 5'd0) committed[dest] = exp_wb();
    if (rst) return 32'h0;
    return committed[s];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // Drive one cycle's inputs. Reset takes effect asynchronously, so the model
  // is emptied as soon as rst is driven high.
  task automatic apply(input logic r, input logic w, input logic m, input logic [31:0] a,
                       input logic [31:0] md, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2);
    rst = r; we = w; mr = m; alu = a; mem = md; dest = d; src1 = s1; src2 = s2;
    if (r) clear_model();
    #2;
  endtask

  // Commit this cycle's write in the model, then cross the clock edge.
  task automatic tick();
    if (!rst && we && dest != 5'd0) model[dest] = exp_wb();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reads(input string tag);
    check($sformatf("%s.reg1", tag), reg1, exp_read(src1));
    check($sformatf("%s.reg2", tag), reg2, exp_read(src2));
    check($sformatf("%s.wb", tag), wb_value, exp_wb());
  endtask

  initial begin
    clear_model();
    rst = 1'b1; we = 1'b0; mr = 1'b0; alu = '0; mem = '0; dest = '0; src1 = 5'd1; src2 = 5'd2;
    #2;
    check("reset.reg1", reg1, 32'h0);
    check("reset.reg2", reg2, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Directed table. The expected values are worked out by hand from an
    // empty register file and applied in order, one clock edge per row.
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_1234, 32'h0,         5'd5, 5'd5, 5'd0, 32'h0000_1234, 32'h0,         32'h0000_1234};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,         32'h0,         5'd0, 5'd5, 5'd5, 32'h0000_1234, 32'h0000_1234, 32'h0};
    vecs[2]  = '{1'b1, 1'b1, 32'h1,         32'hDEAD_BEEF, 5'd7, 5'd7, 5'd5, 32'hDEAD_BEEF, 32'h0000_1234, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b0, 1'b0, 32'h55,        32'h0,         5'd7, 5'd7, 5'd7, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h55};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,         32'h0,         5'd0, 5'd7, 5'd5, 32'hDEAD_BEEF, 32'h0000_1234, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0,         5'd0, 5'd0, 5'd0, 32'h0,         32'h0,         32'hFFFF_FFFF};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,         32'h0,         5'd0, 5'd0, 5'd0, 32'h0,         32'h0,         32'h0};
    vecs[7]  = '{1'b1, 1'b0, 32'h11,        32'h0,         5'd9, 5'd9, 5'd7, 32'h11,        32'hDEAD_BEEF, 32'h11};
    vecs[8]  = '{1'b1, 1'b0, 32'h22,        32'h0,         5'd9, 5'd9, 5'd9, 32'h22,        32'h22,        32'h22};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,         32'h0,         5'd0, 5'd9, 5'd9, 32'h22,        32'h22,        32'h0};
    vecs[10] = '{1'b1, 1'b1, 32'h77,        32'h0,         5'd5, 5'd5, 5'd9, 32'h0,         32'h22,        32'h0};
    vecs[11] = '{1'b0, 1'b0, 32'h0,         32'h0,         5'd0, 5'd5, 5'd31, 32'h0,        32'h0,         32'h0};

    for (int i = 0; i < 12; i++) begin
      apply(1'b0, vecs[i].we, vecs[i].mr, vecs[i].alu, vecs[i].mem, vecs[i].dest, vecs[i].s1, vecs[i].s2);
      check($sformatf("vec%0d.reg1", i), reg1, vecs[i].e1);
      check($sformatf("vec%0d.reg2", i), reg2, vecs[i].e2);
      check($sformatf("vec%0d.wb", i), wb_value, vecs[i].ewb);
      tick();
    end

    // Load r1..r31 with nonzero values. Then raise rst between edges: every
    // read must drop to 0 before any clock edge arrives.
    for (int i = 1; i < 32; i++) begin
      apply(1'b0, 1'b1, 1'b0, 32'hA500_0000 | 32'(i), 32'h0, 5'(i), 5'd0, 5'd0);
      tick();
    end
    apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd31);
    check("loaded.r5", reg1, 32'hA500_0005);
    check("loaded.r31", reg2, 32'hA500_001F);
    tick();
    rst = 1'b1; we = 1'b0; clear_model();
    for (int i = 1; i < 32; i++) begin
      src1 = 5'(i); src2 = 5'(32 - i);
      #0.2;
      check($sformatf("rst_async.r%0d", i), reg1, 32'h0);
      check($sformatf("rst_async.p2_r%0d", 32 - i), reg2, 32'h0);
    end
    mr = 1'b1; mem = 32'hCAFE_F00D; alu = 32'h3;
    #0.2;
    check("rst.wb_follows", wb_value, 32'hCAFE_F00D);
    // This edge arrives with rst still high and must not write r3.
    we = 1'b1; mr = 1'b0; alu = 32'hAB; dest = 5'd3; src1 = 5'd3;
    #0.2;
    check("rst.no_bypass", reg1, 32'h0);
    tick();
    apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd3, 5'd3, 5'd1);
    check("post_rst.r3", reg1, 32'h0);
    check("post_rst.r1", reg2, 32'h0);
    tick();

    // A write is in flight when rst pulses high between edges. The next edge
    // still sees rst high, so r3 must keep the reset value.
    apply(1'b0, 1'b1, 1'b0, 32'h5, 32'h0, 5'd3, 5'd3, 5'd3);
    tick();
    apply(1'b0, 1'b1, 1'b0, 32'hAB, 32'h0, 5'd3, 5'd3, 5'd3);
    check("inflight.bypass", reg1, 32'hAB);
    rst = 1'b1; clear_model();
    #1;
    check("inflight.rst_r3", reg1, 32'h0);
    tick();
    apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd3);
    check("inflight.not_written", reg1, 32'h0);
    tick();
    apply(1'b0, 1'b1, 1'b0, 32'hAB, 32'h0, 5'd3, 5'd0, 5'd0);
    tick();
    apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd3);
    check("first_write_after_rst", reg1, 32'hAB);
    tick();

    // Random traffic. Sources are often steered onto dest so that bypass
    // hits are common.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] d;
      logic [4:0] s1;
      logic [4:0] s2;
      d  = 5'($urandom_range(0, 31));
      s1 = ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31));
      s2 = ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31));
      apply(($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom), $urandom, $urandom, d, s1, s2);
      check_reads($sformatf("rand%0d", n));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
